control_sequencer: RTL and testbench

Hardwired control unit for the MiniSRC datapath. Walks a fixed step sequence (fetch, then per-opcode execute steps) and drives every register-file select line (Gra/Grb/Grc/Rin/Rout/BAout), bus-driver enables, register load enables, memory strobes and the ALU opcode. It sits between the instruction register and the select/encode logic, bus, ALU and memory interface.

---
 rtl/minisrc_pkg.sv | 67 ++++++
 rtl/opcode_class_decode.sv | 36 +++
 rtl/control_sequencer.sv | 134 +++++++++++++
 tb/tb_control_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
// Shared encodings for the MiniSRC control path: opcodes, sequencer steps and
// the one-hot instruction class vector.
package minisrc_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD  = OP_ADD;
  localparam logic [4:0] ALU_NONE = 5'b00000;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } step_t;

  typedef struct packed {
    logic alu_rr;
    logic alu_imm;
    logic unary;
    logic ld;
    logic ldi;
    logic st;
    logic muldiv;
    logic br;
    logic jr;
    logic inp;
    logic outp;
    logic mfhi;
    logic mflo;
    logic nop;
    logic halt;
  } opclass_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Maps the 5-bit opcode to a one-hot instruction class; unassigned codes
// (including 10101) fall into the nop class.
module opcode_class_decode
  import minisrc_pkg::*;
(
  input  logic [4:0] i_opcode,
  output opclass_t   o_class
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_LD:   o_class.ld = 1'b1;
      OP_LDI:  o_class.ldi = 1'b1;
      OP_ST:   o_class.st = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:
               o_class.alu_rr = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:
               o_class.alu_imm = 1'b1;
      OP_DIV, OP_MUL:
               o_class.muldiv = 1'b1;
      OP_NEG, OP_NOT:
               o_class.unary = 1'b1;
      OP_BR:   o_class.br = 1'b1;
      OP_JR:   o_class.jr = 1'b1;
      OP_IN:   o_class.inp = 1'b1;
      OP_OUT:  o_class.outp = 1'b1;
      OP_MFHI: o_class.mfhi = 1'b1;
      OP_MFLO: o_class.mflo = 1'b1;
      OP_HALT: o_class.halt = 1'b1;
      default: o_class.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired MiniSRC control step sequencer; outputs depend on step and IR only.
// state | meaning: RESET idle after reset | T0-T2 fetch | T3-T7 execute | HALT stopped until reset
module control_sequencer
  import minisrc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        OutPortin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run
);

  step_t      r_state;
  step_t      w_next;
  opclass_t   w_cls;
  logic [4:0] w_op;
  logic       w_unused_ir;

  assign w_op = IR[31:27];
  // Register fields are decoded by the select/encode block, not here.
  assign w_unused_ir = ^IR[26:0];

  opcode_class_decode u_decode (
    .i_opcode (w_op),
    .o_class  (w_cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET: w_next = ST_T0;
      ST_T0:    w_next = stop ? ST_T0 : ST_T1;
      ST_T1:    w_next = ST_T2;
      ST_T2:    w_next = w_cls.nop ? ST_T0 : (w_cls.halt ? ST_HALT : ST_T3);
      ST_T3:    w_next = (w_cls.jr | w_cls.inp | w_cls.outp | w_cls.mfhi | w_cls.mflo)
                         ? ST_T0 : ST_T4;
      ST_T4:    w_next = w_cls.unary ? ST_T0 : ST_T5;
      ST_T5:    w_next = (w_cls.alu_rr | w_cls.alu_imm | w_cls.ldi) ? ST_T0 : ST_T6;
      ST_T6:    w_next = (w_cls.muldiv | w_cls.br) ? ST_T0 : ST_T7;
      ST_T7:    w_next = ST_T0;
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_RESET;
    endcase
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; CONin = 1'b0; OutPortin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_op = ALU_NONE;
    run = (r_state != ST_RESET) && (r_state != ST_HALT);
    case (r_state)
      ST_T0: if (!stop) begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        if (w_cls.alu_rr | w_cls.alu_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        if (w_cls.unary) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op; end
        if (w_cls.ld | w_cls.ldi | w_cls.st) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        if (w_cls.muldiv) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        if (w_cls.br)     begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        if (w_cls.jr)     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        if (w_cls.inp)    begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (w_cls.outp)   begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
        if (w_cls.mfhi)   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (w_cls.mflo)   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      ST_T4: begin
        if (w_cls.alu_rr)  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op; end
        if (w_cls.alu_imm) begin Cout = 1'b1; Zin = 1'b1; alu_op = w_op; end
        if (w_cls.unary)   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (w_cls.ld | w_cls.ldi | w_cls.st) begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
        if (w_cls.muldiv)  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op; end
        if (w_cls.br)      begin PCout = 1'b1; Yin = 1'b1; end
      end
      ST_T5: begin
        if (w_cls.alu_rr | w_cls.alu_imm | w_cls.ldi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (w_cls.ld | w_cls.st) begin Zlowout = 1'b1; MARin = 1'b1; end
        if (w_cls.muldiv)        begin Zlowout = 1'b1; LOin = 1'b1; end
        if (w_cls.br)            begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
      end
      ST_T6: begin
        if (w_cls.ld)     begin Read = 1'b1; MDRin = 1'b1; end
        if (w_cls.st)     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        if (w_cls.muldiv) begin Zhighout = 1'b1; HIin = 1'b1; end
        // Branch target is always computed; only the PC load is conditional.
        if (w_cls.br)     begin Zlowout = 1'b1; PCin = CON_FF; end
      end
      ST_T7: begin
        if (w_cls.ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (w_cls.st) Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected list of
// per-clock control sets and compared step by step with the sequencer outputs.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        CON_FF;
  logic        stop;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, Zhighout, Zlowout, MDRout, HIout;
  logic LOout, InPortout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic CONin, OutPortin, IncPC, Read, Write, run;
  logic [4:0] alu_op;

  int checks = 0;
  int failures = 0;

  localparam int GRA = 0, GRB = 1, GRC = 2, RIN = 3, ROUT = 4, BAOUT = 5, PCOUT = 6;
  localparam int ZHI = 7, ZLO = 8, MDROUT = 9, HIOUT = 10, LOOUT = 11, INP = 12;
  localparam int COUT = 13, PCIN = 14, IRIN = 15, MARIN = 16, MDRIN = 17, YIN = 18;
  localparam int ZIN = 19, HIIN = 20, LOIN = 21, CONIN = 22, OUTP = 23, INCPC = 24;
  localparam int READ = 25, WRITE = 26;

  control_sequencer dut (
    .clk(clk), .reset(reset), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );

  always #5 clk = ~clk;

  logic [26:0] obs;
  assign obs = {Write, Read, IncPC, OutPortin, CONin, LOin, HIin, Zin, Yin, MDRin,
                MARin, IRin, PCin, Cout, InPortout, LOout, HIout, MDRout, Zlowout,
                Zhighout, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

  logic [26:0] e_mask [16];
  logic [4:0]  e_alu  [16];
  int          e_len;
  bit          e_halt;

  function automatic logic [26:0] B(int i);
    return 27'(1) << i;
  endfunction

  task automatic push(input logic [26:0] m, input logic [4:0] a);
    e_mask[e_len] = m;
    e_alu[e_len]  = a;
    e_len++;
  endtask

  // Expected per-clock control sets for one instruction, fetch included.
  task automatic build_model(input logic [4:0] op, input logic con);
    e_len = 0;
    e_halt = 0;
    push(B(PCOUT) | B(MARIN) | B(INCPC) | B(ZIN), 5'd0);
    push(B(ZLO) | B(PCIN) | B(READ) | B(MDRIN), 5'd0);
    push(B(MDROUT) | B(IRIN), 5'd0);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(B(GRB) | B(ROUT) | B(YIN), 5'd0);
      push(B(GRC) | B(ROUT) | B(ZIN), op);
      push(B(ZLO) | B(GRA) | B(RIN), 5'd0);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(B(GRB) | B(ROUT) | B(YIN), 5'd0);
      push(B(COUT) | B(ZIN), op);
      push(B(ZLO) | B(GRA) | B(RIN), 5'd0);
    end else if (op == 5'd17 || op == 5'd18) begin
      push(B(GRB) | B(ROUT) | B(ZIN), op);
      push(B(ZLO) | B(GRA) | B(RIN), 5'd0);
    end else if (op <= 5'd2) begin
      push(B(GRB) | B(BAOUT) | B(YIN), 5'd0);
      push(B(COUT) | B(ZIN), 5'd3);
      if (op == 5'd1) push(B(ZLO) | B(GRA) | B(RIN), 5'd0);
      else begin
        push(B(ZLO) | B(MARIN), 5'd0);
        if (op == 5'd0) begin
          push(B(READ) | B(MDRIN), 5'd0);
          push(B(MDROUT) | B(GRA) | B(RIN), 5'd0);
        end else begin
          push(B(GRA) | B(ROUT) | B(MDRIN), 5'd0);
          push(B(WRITE), 5'd0);
        end
      end
    end else if (op == 5'd15 || op == 5'd16) begin
      push(B(GRA) | B(ROUT) | B(YIN), 5'd0);
      push(B(GRB) | B(ROUT) | B(ZIN), op);
      push(B(ZLO) | B(LOIN), 5'd0);
      push(B(ZHI) | B(HIIN), 5'd0);
    end else if (op == 5'd19) begin
      push(B(GRA) | B(ROUT) | B(CONIN), 5'd0);
      push(B(PCOUT) | B(YIN), 5'd0);
      push(B(COUT) | B(ZIN), 5'd3);
      push(B(ZLO) | (con ? B(PCIN) : 27'd0), 5'd0);
    end else if (op == 5'd20) push(B(GRA) | B(ROUT) | B(PCIN), 5'd0);
    else if (op == 5'd22) push(B(INP) | B(GRA) | B(RIN), 5'd0);
    else if (op == 5'd23) push(B(GRA) | B(ROUT) | B(OUTP), 5'd0);
    else if (op == 5'd24) push(B(HIOUT) | B(GRA) | B(RIN), 5'd0);
    else if (op == 5'd25) push(B(LOOUT) | B(GRA) | B(RIN), 5'd0);
    else if (op == 5'd27) e_halt = 1;
  endtask

  task automatic check_all(input string tag, input int k, input logic [26:0] em,
                           input logic [4:0] ea, input logic er);
    checks++;
    assert (obs === em) else begin
      failures++;
      $error("FAIL %s step%0d strobes got=%h exp=%h", tag, k, obs, em);
    end
    checks++;
    assert (alu_op === ea) else begin
      failures++;
      $error("FAIL %s step%0d alu_op got=%b exp=%b", tag, k, alu_op, ea);
    end
    checks++;
    assert (run === er) else begin
      failures++;
      $error("FAIL %s step%0d run got=%b exp=%b", tag, k, run, er);
    end
  endtask

  // Entered in T0 just after an edge; leaves in the cycle after the last step.
  task automatic run_instr(input logic [31:0] ir, input logic con, input string tag);
    IR = ir;
    CON_FF = con;
    build_model(ir[31:27], con);
    for (int k = 0; k < e_len; k++) begin
      check_all(tag, k, e_mask[k], e_alu[k], 1'b1);
      @(posedge clk); #1;
    end
  endtask

  localparam logic [26:0] FETCH0 = 27'(1) << 6 | 27'(1) << 16 | 27'(1) << 24 | 27'(1) << 19;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  rop;
    logic [31:0] rir;
    reset = 1'b1; stop = 1'b0; IR = 32'd0; CON_FF = 1'b0;
    @(posedge clk); #1;
    check_all("reset_state", 0, 27'd0, 5'd0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_instr(32'h19888000, 1'b0, "add");
    run_instr(32'h00900055, 1'b0, "ld");
    run_instr(32'h99800004, 1'b0, "br_con0");
    run_instr(32'h99800004, 1'b1, "br_con1");
    run_instr(32'hA8000000, 1'b0, "op10101_nop");
    run_instr(32'hD0000000, 1'b0, "nop");

    // Reset in the middle of a store, at T5.
    IR = 32'h10000000;
    CON_FF = 1'b0;
    build_model(5'd2, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check_all("st_pre_reset", k, e_mask[k], e_alu[k], 1'b1);
      if (k < 5) begin @(posedge clk); #1; end
    end
    reset = 1'b1;
    #1;
    check_all("reset_mid_st", 5, 27'd0, 5'd0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("t0_after_reset", 0, FETCH0, 5'd0, 1'b1);

    // Pause at T0 for five clocks.
    stop = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_all("stop_hold", i, 27'd0, 5'd0, 1'b1);
      @(posedge clk); #1;
    end
    stop = 1'b0;
    #1;
    run_instr(32'h08800010, 1'b0, "ldi_after_stop");

    for (int i = 0; i < 60; i++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'd27) rop = 5'd26;
      rir = {rop, 27'($urandom)};
      run_instr(rir, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, rop));
    end

    run_instr(32'hD8000000, 1'b0, "halt_fetch");
    for (int i = 0; i < 20; i++) begin
      check_all("halt_hold", i, 27'd0, 5'd0, 1'b0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check_all("halt_reset", 0, 27'd0, 5'd0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("t0_after_halt", 0, FETCH0, 5'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
